// File: rtl/hash_reg_initiator.sv
// Bus initiator for a hash core's register window: loads message blocks, starts
// the core, polls for completion and returns the digest on a valid/ready port.
module hash_reg_initiator #(
    parameter int unsigned          DataWidth     = 64,
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          DataBytes     = DataWidth / 8,
    parameter int unsigned          BlockWidth    = 512,
    parameter int unsigned          DigestWidth   = 256,
    parameter bit                   ByteAlign     = 1'b1,
    parameter logic [AddrWidth-1:0] BaseAddr      = '0,
    parameter int unsigned          TimeoutCycles = 256,
    parameter int unsigned          PollGap       = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   blk_valid_i,
    output logic                   blk_ready_o,
    input  logic [BlockWidth-1:0]  blk_i,
    input  logic                   blk_last_i,
    output logic                   digest_valid_o,
    input  logic                   digest_ready_i,
    output logic [DigestWidth-1:0] digest_o,
    output logic                   busy_o,
    output logic                   error_o,
    input  logic                   clear_err_i,
    output logic [DataWidth-1:0]   reqdata_o,
    output logic [AddrWidth-1:0]   reqaddr_o,
    output logic                   reqvalid_o,
    output logic                   reqwrite_o,
    input  logic                   reqready_i,
    output logic [DataBytes-1:0]   reqstrobe_o,
    output logic                   rspready_o,
    input  logic                   rspvalid_i,
    input  logic [DataWidth-1:0]   rspdata_i,
    input  logic                   rsperror_i
);
    localparam int unsigned BlRegs = BlockWidth / DataWidth;
    localparam int unsigned DiRegs = (DigestWidth + DataWidth - 1) / DataWidth;
    localparam int unsigned Step   = ByteAlign ? DataWidth / 8 : DataWidth / 32;
    localparam int unsigned IdxW   = $clog2(BlRegs + DiRegs + 1);
    localparam int unsigned TmoW   = $clog2(TimeoutCycles + 1);
    localparam int unsigned GapW   = $clog2(PollGap + 2);

    localparam logic [IdxW-1:0] BlLast  = IdxW'(BlRegs - 1);
    localparam logic [IdxW-1:0] DiLast  = IdxW'(DiRegs - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
    localparam logic [GapW-1:0] GapInit = GapW'(PollGap);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RSTWR  = 3'd1;
    localparam logic [2:0] BLKWR  = 3'd2;
    localparam logic [2:0] CTRLWR = 3'd3;
    localparam logic [2:0] POLL   = 3'd4;
    localparam logic [2:0] DIGRD  = 3'd5;
    localparam logic [2:0] DIGOUT = 3'd6;
    localparam logic [2:0] ERR    = 3'd7;

    logic [2:0]                  r_state;
    logic                        r_first;
    logic                        r_err;
    logic                        r_wait;
    logic [IdxW-1:0]             r_idx;
    logic [TmoW-1:0]             r_tmo;
    logic [GapW-1:0]             r_gap;
    logic [BlockWidth-1:0]       r_blk;
    logic                        r_last;
    logic [DiRegs*DataWidth-1:0] r_dig;

    logic                 w_req_state;
    logic                 w_issue;
    logic                 w_write;
    logic                 w_done;
    logic                 w_fail;
    logic [AddrWidth-1:0] w_off;
    logic [DataWidth-1:0] w_wdata;

    assign w_req_state = (r_state == RSTWR) || (r_state == BLKWR) || (r_state == CTRLWR) ||
                         (r_state == POLL)  || (r_state == DIGRD);
    // Requests go out only when the responder is ready, so reqvalid_o is never held.
    assign w_issue = w_req_state && !r_wait && (r_gap == '0) && reqready_i;
    assign w_write = (r_state == RSTWR) || (r_state == BLKWR) || (r_state == CTRLWR);
    assign w_done  = r_wait && rspvalid_i && !rsperror_i;
    assign w_fail  = r_wait && (rspvalid_i ? rsperror_i : (r_tmo == TmoLast));

    always_comb begin
        w_off   = '0;
        w_wdata = '0;
        case (r_state)
            RSTWR:  w_wdata = DataWidth'(2);
            BLKWR: begin
                w_off   = AddrWidth'(12'h100) + AddrWidth'(r_idx) * AddrWidth'(Step);
                w_wdata = r_blk[r_idx*DataWidth +: DataWidth];
            end
            CTRLWR: w_wdata = DataWidth'({r_last, 5'b00001});
            DIGRD:  w_off   = AddrWidth'(12'h200) + AddrWidth'(r_idx) * AddrWidth'(Step);
            default: ;
        endcase
    end

    assign reqvalid_o     = w_issue;
    assign reqwrite_o     = w_issue && w_write;
    assign reqaddr_o      = w_issue ? (BaseAddr + w_off) : '0;
    assign reqdata_o      = (w_issue && w_write) ? w_wdata : '0;
    assign reqstrobe_o    = (w_issue && w_write) ? '1 : '0;
    assign rspready_o     = r_wait;
    assign blk_ready_o    = rst_ni && (r_state == IDLE);
    assign digest_valid_o = (r_state == DIGOUT);
    assign digest_o       = r_dig[DigestWidth-1:0];
    assign busy_o         = (r_state != IDLE) && (r_state != ERR);
    assign error_o        = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_first <= 1'b1;
            r_err   <= 1'b0;
            r_wait  <= 1'b0;
            r_idx   <= '0;
            r_tmo   <= '0;
            r_gap   <= '0;
            r_blk   <= '0;
            r_last  <= 1'b0;
            r_dig   <= '0;
        end else begin
            if (w_issue) begin
                r_wait <= 1'b1;
                r_tmo  <= '0;
            end else if (r_wait && !rspvalid_i && (r_tmo != TmoLast)) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (r_gap != '0) r_gap <= r_gap - 1'b1;

            if (w_fail) begin
                r_wait  <= 1'b0;
                r_err   <= 1'b1;
                r_idx   <= '0;
                r_gap   <= '0;
                r_state <= ERR;
            end else if (w_done) begin
                r_wait <= 1'b0;
                case (r_state)
                    RSTWR: begin
                        r_first <= 1'b0;
                        r_idx   <= '0;
                        r_state <= BLKWR;
                    end
                    BLKWR: begin
                        if (r_idx == BlLast) begin
                            r_idx   <= '0;
                            r_state <= CTRLWR;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    CTRLWR: begin
                        r_gap   <= GapInit;
                        r_state <= POLL;
                    end
                    POLL: begin
                        // Intermediate blocks finish when the core drops enable;
                        // the final block finishes when the digest is flagged valid.
                        if (!r_last && !rspdata_i[0]) begin
                            r_state <= IDLE;
                        end else if (r_last && rspdata_i[4]) begin
                            r_idx   <= '0;
                            r_state <= DIGRD;
                        end else begin
                            r_gap <= GapInit;
                        end
                    end
                    DIGRD: begin
                        r_dig[r_idx*DataWidth +: DataWidth] <= rspdata_i;
                        if (r_idx == DiLast) begin
                            r_idx   <= '0;
                            r_state <= DIGOUT;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                case (r_state)
                    IDLE: begin
                        if (blk_valid_i) begin
                            r_blk   <= blk_i;
                            r_last  <= blk_last_i;
                            r_idx   <= '0;
                            r_state <= r_first ? RSTWR : BLKWR;
                        end
                    end
                    DIGOUT: begin
                        if (digest_ready_i) begin
                            r_first <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    ERR: begin
                        if (clear_err_i) begin
                            r_err   <= 1'b0;
                            r_first <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hash_reg_initiator.sv
// Bench for hash_reg_initiator: register responder model, transaction scoreboard
// and a message table, plus error, timeout, back-pressure and reset sequences.
module tb_hash_reg_initiator;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blk_valid = 1'b0;
    logic [511:0] blk = '0;
    logic         blk_last = 1'b0;
    logic         digest_ready = 1'b0;
    logic         clear_err = 1'b0;
    logic         rr = 1'b1;
    logic         rspvalid = 1'b0;
    logic [63:0]  rspdata = '0;
    logic         rsperror = 1'b0;

    logic         blk_ready_o, digest_valid_o, busy_o, error_o;
    logic [255:0] digest_o;
    logic [63:0]  reqdata_o;
    logic [31:0]  reqaddr_o;
    logic         reqvalid_o, reqwrite_o, rspready_o;
    logic [7:0]   reqstrobe_o;

    logic         blk_ready_o0, digest_valid_o0, busy_o0, error_o0;
    logic [255:0] digest_o0;
    logic [63:0]  reqdata_o0;
    logic [31:0]  reqaddr_o0;
    logic         reqvalid_o0, reqwrite_o0, rspready_o0;
    logic [7:0]   reqstrobe_o0;

    always #5 clk = ~clk;

    hash_reg_initiator u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .blk_valid_i(blk_valid), .blk_ready_o(blk_ready_o), .blk_i(blk), .blk_last_i(blk_last),
        .digest_valid_o(digest_valid_o), .digest_ready_i(digest_ready), .digest_o(digest_o),
        .busy_o(busy_o), .error_o(error_o), .clear_err_i(clear_err),
        .reqdata_o(reqdata_o), .reqaddr_o(reqaddr_o), .reqvalid_o(reqvalid_o),
        .reqwrite_o(reqwrite_o), .reqready_i(rr), .reqstrobe_o(reqstrobe_o),
        .rspready_o(rspready_o), .rspvalid_i(rspvalid), .rspdata_i(rspdata), .rsperror_i(rsperror)
    );

    // Word-addressed twin fed the same inputs; it runs in lockstep with u_dut.
    hash_reg_initiator #(.ByteAlign(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .blk_valid_i(blk_valid), .blk_ready_o(blk_ready_o0), .blk_i(blk), .blk_last_i(blk_last),
        .digest_valid_o(digest_valid_o0), .digest_ready_i(digest_ready), .digest_o(digest_o0),
        .busy_o(busy_o0), .error_o(error_o0), .clear_err_i(clear_err),
        .reqdata_o(reqdata_o0), .reqaddr_o(reqaddr_o0), .reqvalid_o(reqvalid_o0),
        .reqwrite_o(reqwrite_o0), .reqready_i(rr), .reqstrobe_o(reqstrobe_o0),
        .rspready_o(rspready_o0), .rspvalid_i(rspvalid), .rspdata_i(rspdata), .rsperror_i(rsperror)
    );

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] a0;
        logic [63:0] d;
    } txn_t;

    typedef struct {
        logic [511:0] blk;
        logic         last;
        int           busy;
        logic [63:0]  salt;
    } vec_t;

    txn_t exp_q[$];
    vec_t vecs[7];
    int   total = 0;
    int   bad = 0;
    bit   first = 1'b1;

    bit          pend = 1'b0;
    int          cnt = 0;
    logic [63:0] pdata = '0;
    logic        perr = 1'b0;
    bit          silent = 1'b0;
    bit          err_inj = 1'b0;
    int          blkwr_seen = 0;
    int          busy_cfg = 0;
    int          busy_left = 0;
    logic        cur_last = 1'b0;
    logic [63:0] salt = '0;
    int          cyc = 0;
    int          req_cyc = 0;

    task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    function automatic logic [63:0] dword(input logic [63:0] s, input int d);
        return s ^ (64'h0101_0101_0101_0101 * 64'(d + 1));
    endfunction

    function automatic logic [511:0] rblk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Responder: answers each request one cycle after issue; also the scoreboard checker.
    always @(negedge clk) begin
        cyc++;
        rspvalid = 1'b0;
        rsperror = 1'b0;
        rspdata  = '0;
        if (pend) begin
            if (cnt == 0) begin
                rspvalid = 1'b1;
                rsperror = perr;
                rspdata  = pdata;
                pend     = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (!rr) chk("reqvalid_while_not_ready", reqvalid_o, 0);
        if (reqvalid_o) begin
            txn_t e;
            req_cyc = cyc;
            chk("reqvalid_twin", reqvalid_o0, 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_req", reqvalid_o, 0);
            end else begin
                e = exp_q.pop_front();
                chk("req_write", reqwrite_o, e.wr);
                chk("req_addr", reqaddr_o, e.a);
                chk("req_addr_wordalign", reqaddr_o0, e.a0);
                chk("req_data", reqdata_o, e.d);
                chk("req_strobe", reqstrobe_o, e.wr ? 8'hff : 8'h00);
            end
            perr  = 1'b0;
            pdata = '0;
            if (reqwrite_o && reqaddr_o >= 32'h100 && reqaddr_o < 32'h200) begin
                blkwr_seen++;
                if (err_inj && blkwr_seen == 3) perr = 1'b1;
            end
            if (reqwrite_o && reqaddr_o == 32'h0 && reqdata_o[0]) begin
                cur_last  = reqdata_o[5];
                busy_left = busy_cfg;
            end
            if (!reqwrite_o && reqaddr_o == 32'h0) begin
                if (busy_left > 0) begin
                    pdata = 64'h1;
                    busy_left--;
                end else begin
                    pdata = cur_last ? 64'h10 : 64'h4;
                end
            end
            if (!reqwrite_o && reqaddr_o >= 32'h200) pdata = dword(salt, int'((reqaddr_o - 32'h200) >> 3));
            if (!silent) begin
                pend = 1'b1;
                cnt  = 0;
            end
        end
    end

    task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] a0, input logic [63:0] d);
        txn_t t;
        t.wr = wr; t.a = a; t.a0 = a0; t.d = d;
        exp_q.push_back(t);
    endtask

    task automatic push_head(input bit f, input logic [511:0] b, input int nwr);
        if (f) push(1'b1, 32'h0, 32'h0, 64'h2);
        for (int r = 0; r < nwr; r++)
            push(1'b1, 32'h100 + 32'(r * 8), 32'h100 + 32'(r * 2), b[r*64 +: 64]);
    endtask

    task automatic push_tail(input vec_t v);
        push(1'b1, 32'h0, 32'h0, v.last ? 64'h21 : 64'h1);
        for (int p = 0; p <= v.busy; p++) push(1'b0, 32'h0, 32'h0, 64'h0);
        if (v.last)
            for (int d = 0; d < 4; d++) push(1'b0, 32'h200 + 32'(d * 8), 32'h200 + 32'(d * 2), 64'h0);
    endtask

    task automatic send_block(input logic [511:0] b, input logic l);
        @(negedge clk);
        blk = b; blk_last = l; blk_valid = 1'b1;
        for (int i = 0; i < 200 && !blk_ready_o; i++) @(negedge clk);
        chk("blk_ready_wait", blk_ready_o, 1);
        @(posedge clk);
        #1 blk_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string n);
        chk(n, {blk_ready_o, reqvalid_o, reqwrite_o, reqaddr_o, reqdata_o, reqstrobe_o,
                rspready_o, digest_valid_o, busy_o, error_o, blk_ready_o0, reqvalid_o0}, 0);
        chk({n, "_digest"}, digest_o, 0);
    endtask

    task automatic run_msg(input vec_t v);
        logic [255:0] expd, hold;
        salt = v.salt; busy_cfg = v.busy; blkwr_seen = 0;
        push_head(first, v.blk, 8);
        push_tail(v);
        send_block(v.blk, v.last);
        if (v.last) begin
            expd = {dword(v.salt, 3), dword(v.salt, 2), dword(v.salt, 1), dword(v.salt, 0)};
            for (int i = 0; i < 3000 && !digest_valid_o; i++) @(negedge clk);
            chk("digest_valid", digest_valid_o, 1);
            chk("digest", digest_o, expd);
            chk("digest_wordalign", digest_o0, expd);
            hold = digest_o;
            repeat (3) @(negedge clk);
            chk("digest_held_valid", digest_valid_o, 1);
            chk("digest_held_value", digest_o, hold);
            digest_ready = 1'b1;
            @(posedge clk);
            #1 digest_ready = 1'b0;
            @(negedge clk);
            chk("digest_consumed", digest_valid_o, 0);
            chk("idle_after_digest", blk_ready_o, 1);
            first = 1'b1;
        end else begin
            for (int i = 0; i < 3000 && busy_o; i++) @(negedge clk);
            chk("idle_after_block", {busy_o, blk_ready_o}, 2'b01);
            first = 1'b0;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic clear_error();
        @(posedge clk);
        #1 clear_err = 1'b1;
        @(posedge clk);
        #1 clear_err = 1'b0;
        @(negedge clk);
        chk("err_cleared", {error_o, blk_ready_o, busy_o}, 3'b010);
        first = 1'b1;
    endtask

    initial begin
        vecs[0] = '{rblk(), 1'b1, 2, 64'hA5A5_0000_1234_5678};
        vecs[1] = '{rblk(), 1'b0, 1, 64'h0};
        vecs[2] = '{rblk(), 1'b1, 0, 64'h1357_9BDF_0246_8ACE};
        vecs[3] = '{rblk(), 1'b1, 3, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[4] = '{rblk(), 1'b0, 0, 64'h0};
        vecs[5] = '{rblk(), 1'b0, 2, 64'h0};
        vecs[6] = '{rblk(), 1'b1, 1, 64'h0F0F_F0F0_5A5A_A5A5};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {blk_ready_o, busy_o, error_o}, 3'b100);

        for (int i = 0; i < 7; i++) run_msg(vecs[i]);

        // Error response on the third block write.
        err_inj = 1'b1; blkwr_seen = 0;
        push_head(first, vecs[0].blk, 3);
        send_block(vecs[0].blk, 1'b1);
        for (int i = 0; i < 500 && !error_o; i++) @(negedge clk);
        chk("err_flag", {error_o, blk_ready_o, busy_o}, 3'b100);
        repeat (20) @(negedge clk);
        chk("err_no_more_reqs", exp_q.size(), 0);
        chk("err_sticky", error_o, 1);
        err_inj = 1'b0;
        clear_error();
        run_msg(vecs[2]);

        // Silent responder: timeout after TimeoutCycles waiting cycles.
        silent = 1'b1;
        push_head(first, vecs[3].blk, 0);
        send_block(vecs[3].blk, 1'b1);
        for (int i = 0; i < 400 && !error_o; i++) @(negedge clk);
        #1;
        chk("timeout_flag", error_o, 1);
        chk("timeout_cycles", cyc - req_cyc, 257);
        repeat (10) @(negedge clk);
        chk("timeout_no_repulse", exp_q.size(), 0);
        silent = 1'b0;
        clear_error();

        // Back-pressure, then reset in the middle of the block writes.
        @(posedge clk);
        #1 rr = 1'b0;
        blkwr_seen = 0;
        push_head(first, vecs[4].blk, 8);
        send_block(vecs[4].blk, 1'b0);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 rr = 1'b1;
        #1 chk("req_on_first_ready", reqvalid_o, 1);
        for (int i = 0; i < 100 && blkwr_seen < 3; i++) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midtxn_reset");
        exp_q.delete();
        pend = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        first = 1'b1;
        run_msg(vecs[5]);
        run_msg(vecs[6]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
